// File: rtl/mm_job_sched.sv
`timescale 1ns/1ps
// Purpose: sequences one matmul job: validates the descriptor, derives size words, starts the multiply and checks the mm2s stream.
// Latency: descriptor to start_mult is (M3/BW)+4 cycles; job_done follows the final beat (or the watchdog) by one cycle.
// Backpressure: job_ready is high only in IDLE, so descriptors offered while busy are held off, never dropped.
module mm_job_sched #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int MATRIXSIZE_W = 16,
    parameter int TIMEOUT_W    = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [MATRIXSIZE_W-1:0] job_m1,
    input  logic [MATRIXSIZE_W-1:0] job_m3,
    input  logic [MATRIXSIZE_W-1:0] job_bw,
    output logic [MATRIXSIZE_W-1:0] cfg_blocks,
    output logic [MATRIXSIZE_W-1:0] cfg_block_width,
    output logic [MATRIXSIZE_W-1:0] cfg_m1xbwdn1,
    output logic [MATRIXSIZE_W-1:0] cfg_m1dn1,
    output logic [MATRIXSIZE_W-1:0] cfg_m1xm3dn1,
    output logic                    start_mult,
    input  logic                    done_multiply,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    input  logic                    mon_tlast,
    output logic                    busy,
    output logic                    job_done,
    output logic                    job_err,
    output logic [2:0]              err_code
);
    localparam int MSW = MATRIXSIZE_W;
    localparam int L   = $clog2(N1);
    localparam logic [MSW-1:0] N1_W = MSW'(N1);
    localparam logic [MSW-1:0] N2_W = MSW'(N2);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_SIZE    = 3'd1;
    localparam logic [2:0] ERR_OVF     = 3'd2;
    localparam logic [2:0] ERR_EARLY   = 3'd3;
    localparam logic [2:0] ERR_MISSING = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_DIV, S_CHECK, S_START, S_COMPUTE, S_DRAIN, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [MSW-1:0]       m1_q, m3_q, bw_q, rem_q, blk_q;
    logic [2:0]           err_q;
    logic [2*MSW-1:0]     beat_q;
    logic [TIMEOUT_W-1:0] wd_q;
    logic                 start_q;

    logic [MSW-1:0]       m1dn1;
    logic [2*MSW-1:0]     prod_bw, prod_m3, beat_total, beat_nxt;
    logic                 bad_size, ovf, beat, wd_sat, div_go;
    logic [2:0]           chk_code;
    logic                 err_load;
    logic [2:0]           err_new;

    // Derived sizes, validation result and stream/watchdog conditions.
    always_comb begin
        m1dn1      = m1_q >> L;
        prod_bw    = {{MSW{1'b0}}, m1dn1} * {{MSW{1'b0}}, bw_q};
        prod_m3    = {{MSW{1'b0}}, m1dn1} * {{MSW{1'b0}}, m3_q};
        beat_total = {{MSW{1'b0}}, cfg_m1xm3dn1} << L;
        beat_nxt   = beat_q + 1'b1;
        beat       = mon_tvalid & mon_tready;
        wd_sat     = &wd_q;
        div_go     = (bw_q != '0) && (rem_q >= bw_q);
        bad_size   = (m1_q == '0) || (m3_q == '0) || (bw_q == '0) ||
                     ((m1_q % N1_W) != '0) || ((bw_q % N2_W) != '0) || (rem_q != '0);
        ovf        = (prod_bw[2*MSW-1:MSW] != '0) || (prod_m3[2*MSW-1:MSW] != '0);
        chk_code   = bad_size ? ERR_SIZE : (ovf ? ERR_OVF : ERR_OK);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state, handshake/status outputs and error capture decisions.
    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        busy      = 1'b1;
        job_done  = 1'b0;
        job_err   = 1'b0;
        err_load  = 1'b0;
        err_new   = ERR_OK;
        err_code  = err_q;
        case (state)
            S_IDLE: begin
                busy      = 1'b0;
                job_ready = 1'b1;
                if (job_valid) state_nxt = S_DIV;
            end
            S_DIV: begin
                if (!div_go) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // A rejected descriptor reports in this cycle and never reaches START.
                err_code = chk_code;
                if (chk_code != ERR_OK) begin
                    job_done  = 1'b1;
                    job_err   = 1'b1;
                    err_load  = 1'b1;
                    err_new   = chk_code;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (done_multiply) begin
                    state_nxt = S_DRAIN;
                end else if (wd_sat) begin
                    err_load  = 1'b1;
                    err_new   = ERR_TIMEOUT;
                    state_nxt = S_DONE;
                end
            end
            S_DRAIN: begin
                if (beat && mon_tlast) begin
                    err_load  = 1'b1;
                    err_new   = (beat_nxt == beat_total) ? ERR_OK : ERR_EARLY;
                    state_nxt = S_DONE;
                end else if (beat && (beat_nxt == beat_total)) begin
                    err_load  = 1'b1;
                    err_new   = ERR_MISSING;
                    state_nxt = S_DONE;
                end else if (!beat && wd_sat) begin
                    err_load  = 1'b1;
                    err_new   = ERR_TIMEOUT;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                job_done  = 1'b1;
                job_err   = (err_q != ERR_OK);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign start_mult = start_q;

    // Descriptor capture, division, config registers, beat counter and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q            <= '0;
            m3_q            <= '0;
            bw_q            <= '0;
            rem_q           <= '0;
            blk_q           <= '0;
            err_q           <= ERR_OK;
            beat_q          <= '0;
            wd_q            <= '0;
            start_q         <= 1'b0;
            cfg_blocks      <= '0;
            cfg_block_width <= '0;
            cfg_m1xbwdn1    <= '0;
            cfg_m1dn1       <= '0;
            cfg_m1xm3dn1    <= '0;
        end else begin
            // start_mult trails the cycle in which cfg_* first become valid.
            start_q <= (state == S_START);
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        m1_q  <= job_m1;
                        m3_q  <= job_m3;
                        bw_q  <= job_bw;
                        rem_q <= job_m3;
                        blk_q <= '0;
                        err_q <= ERR_OK;
                    end
                end
                S_DIV: begin
                    if (div_go) begin
                        rem_q <= rem_q - bw_q;
                        blk_q <= blk_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (chk_code == ERR_OK) begin
                        cfg_blocks      <= blk_q;
                        cfg_block_width <= bw_q;
                        cfg_m1xbwdn1    <= prod_bw[MSW-1:0];
                        cfg_m1dn1       <= m1dn1;
                        cfg_m1xm3dn1    <= prod_m3[MSW-1:0];
                    end
                end
                S_START: begin
                    wd_q   <= '0;
                    beat_q <= '0;
                end
                S_COMPUTE: begin
                    // Leaving for DRAIN restarts the watchdog for the stream phase.
                    if (done_multiply)  wd_q <= '0;
                    else if (!wd_sat)   wd_q <= wd_q + 1'b1;
                end
                S_DRAIN: begin
                    if (beat) begin
                        beat_q <= beat_nxt;
                        wd_q   <= '0;
                    end else if (!wd_sat) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: ;
            endcase
            if (err_load) err_q <= err_new;
        end
    end
endmodule
